ramsp: RTL and testbench

RAMSP -- requirements
Module: ramsp

---
 rtl/ramsp_pkg.sv | 12 +
 rtl/ramsp_clr.sv | 55 +++++
 rtl/ramsp.sv | 83 ++++++++
 tb/tb_ramsp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ramsp_pkg.sv
// Shared types and constants for the single-port RAM with clear sequencer.
package ramsp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int unsigned RDW_WFIRST = 0;
  localparam int unsigned RDW_RFIRST = 1;

endpackage

// File: rtl/ramsp_clr.sv
// Clear sequencer: walks every address once, writing zero, while busy is high.
module ramsp_clr
  import ramsp_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;

  // Reset lands in CLEAR so the array is zeroed before first use.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == '1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/ramsp.sv
// Single-port byte-masked RAM with built-in clear sequencer.
// Define RAMSP_OREG_EN to add an output pipeline register (read latency 2).
module ramsp
  import ramsp_pkg::*;
#(
  parameter  int unsigned DW  = 16,
  parameter  int unsigned AW  = 10,
  parameter  int unsigned BW  = 8,
  parameter  int unsigned RDW = RDW_WFIRST,
  localparam int unsigned NB  = DW / BW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          ce,
  input  logic          we,
  input  logic [NB-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          busy,
  output logic [DW-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          acc, wr;
  logic [DW-1:0] rd_old, wr_word, rd_word, dout_q;

  ramsp_clr #(.AW(AW)) u_clr (
    .clk      (clk),
    .nreset   (nreset),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    acc     = ce && !busy;
    wr      = acc && we;
    rd_old  = mem[addr];
    wr_word = rd_old;
    for (int unsigned i = 0; i < NB; i++) begin
      if (wmask[i]) wr_word[i*BW +: BW] = din[i*BW +: BW];
    end
    rd_word = (RDW == RDW_WFIRST && we) ? wr_word : rd_old;
  end

  // Clear writes take the port whenever the sequencer runs; user writes are gated by busy.
  always_ff @(posedge clk) begin
    if (clr_we)  mem[clr_addr] <= '0;
    else if (wr) mem[addr]     <= wr_word;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)  dout_q <= '0;
    else if (acc) dout_q <= rd_word;
  end

`ifdef RAMSP_OREG_EN
  logic          ld_q;
  logic [DW-1:0] dout_p;

  // Second stage captures only data freshly loaded into the first stage.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ld_q   <= 1'b0;
      dout_p <= '0;
    end else begin
      ld_q <= acc;
      if (ld_q) dout_p <= dout_q;
    end
  end

  assign dout = dout_p;
`else
  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_ramsp.sv
// Randomized self-checking bench for ramsp (AW=4), write-first and read-first instances side by side.
module tb_ramsp;

  localparam int DEPTH = 16;
`ifdef RAMSP_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        ce = 1'b0, we = 1'b0, clr = 1'b0;
  logic [1:0]  wmask = '0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;
  logic        busy0, busy1;
  logic [15:0] dout0, dout1;

  always #5 clk = ~clk;

  ramsp #(.DW(16), .AW(4), .BW(8), .RDW(0)) u_wf (
    .clk(clk), .nreset(nreset), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .clr(clr), .busy(busy0), .dout(dout0)
  );

  ramsp #(.DW(16), .AW(4), .BW(8), .RDW(1)) u_rf (
    .clk(clk), .nreset(nreset), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .clr(clr), .busy(busy1), .dout(dout1)
  );

  int n_cmp = 0, n_bad = 0;
  bit started = 0;

  // Reference: array contents, remaining clear cycles, and the read-data pipeline.
  logic [15:0] m_mem [DEPTH];
  int          m_left;
  logic [15:0] s0, s1, p0, p1;
  bit          m_ld;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_wf();
    return (LAT == 2) ? p0 : s0;
  endfunction

  function automatic logic [15:0] exp_rf();
    return (LAT == 2) ? p1 : s1;
  endfunction

  task automatic model_reset();
    m_left = DEPTH;
    s0 = '0; s1 = '0; p0 = '0; p1 = '0;
    m_ld = 0;
  endtask

  task automatic model_edge();
    logic [15:0] old_w, new_w;
    bit ld;
    ld = 0; old_w = '0; new_w = '0;
    if (!nreset) return;
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = '0;
      m_left--;
    end else begin
      if (ce) begin
        ld    = 1;
        old_w = m_mem[addr];
        if (we)
          for (int l = 0; l < 2; l++)
            if (wmask[l]) m_mem[addr][l*8 +: 8] = din[l*8 +: 8];
        new_w = m_mem[addr];
      end
      if (clr) m_left = DEPTH;
    end
    if (m_ld) begin p0 = s0; p1 = s1; end
    if (ld)   begin s0 = new_w; s1 = old_w; end
    m_ld = ld;
  endtask

  // One clock: drive at negedge, advance model at posedge, return 1 time unit later.
  task automatic step(input logic c, input logic w, input logic [1:0] m,
                      input logic [3:0] a, input logic [15:0] d, input logic cl);
    @(negedge clk);
    ce = c; we = w; wmask = m; addr = a; din = d; clr = cl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 4'd0, 16'h0000, 0);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [15:0] exp, input string name);
    step(1, 0, 2'b00, a, 16'h0000, 0);
    if (LAT == 2) idle();
    check(name, dout0, exp);
  endtask

  task automatic busy_len(input string name);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      idle();
      n++;
    end
    check(name, 16'(n), 16'd16);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_left > 0 && n < 40) begin
      idle();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("busy_wf", {15'b0, busy0}, {15'b0, m_left > 0});
      check("busy_rf", {15'b0, busy1}, {15'b0, m_left > 0});
      check("dout_wf", dout0, exp_wf());
      check("dout_rf", dout1, exp_rf());
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'hDEAD;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout0, 16'h0000);
    check("reset_busy", {15'b0, busy0}, 16'h0001);
    nreset = 1'b1;
    started = 1;
    busy_len("init_busy_len");
    for (int i = 0; i < DEPTH; i++) rd_chk(4'(i), 16'h0000, "init_zero");

    // Lane-masked partial overwrite.
    step(1, 1, 2'b11, 4'd3, 16'hBEEF, 0);
    step(1, 1, 2'b10, 4'd3, 16'h12AB, 0);
    rd_chk(4'd3, 16'h12EF, "mask_merge");

    // Read-during-write on the same address.
    step(1, 1, 2'b11, 4'd7, 16'h1111, 0);
    step(1, 1, 2'b11, 4'd7, 16'hA5A5, 0);
    if (LAT == 2) idle();
    check("rdw_wfirst", dout0, 16'hA5A5);
    check("rdw_rfirst", dout1, 16'h1111);

    step(1, 1, 2'b11, 4'd2, 16'h0F0F, 0);
    rd_chk(4'd2, 16'h0F0F, "read_2");

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 59) == 0);
    wait_idle();

    // Clear with a second clr pulse and write attempts while busy.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 2'b11, 4'(i), 16'(16'h1000 + i), 0);
    step(0, 0, 2'b00, 4'd0, 16'h0000, 1);
    n = 0;
    while (busy0 && n < 40) begin
      step(1, 1, 2'b11, 4'($urandom_range(0, 15)), 16'hFFFF, n == 4);
      n++;
    end
    check("clr_busy_len", 16'(n), 16'd16);
    for (int i = 0; i < DEPTH; i++) rd_chk(4'(i), 16'h0000, "clr_zero");

    // Reset in the middle of a clear.
    step(1, 1, 2'b11, 4'd5, 16'hCAFE, 0);
    rd_chk(4'd5, 16'hCAFE, "pre_reset_read");
    step(0, 0, 2'b00, 4'd0, 16'h0000, 1);
    repeat (8) idle();
    nreset = 1'b0;
    model_reset();
    #1;
    check("midclr_reset_dout", dout0, 16'h0000);
    check("midclr_reset_busy", {15'b0, busy0}, 16'h0001);
    repeat (2) idle();
    nreset = 1'b1;
    busy_len("reset_busy_len");
    for (int i = 0; i < DEPTH; i++) rd_chk(4'(i), 16'h0000, "reset_zero");

    started = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
